// File: rtl/switch_mode_bank_if.sv
// Signal bundle between board switches / UART command decoder (master side)
// and the switch_mode_bank mode register (slave side).
`timescale 1ns/1ps
interface switch_mode_bank_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0] sw;
  logic [NUM_CH-1:0] uart_toggle;
  logic              uart_wr;
  logic [NUM_CH-1:0] uart_wdata;
  logic [NUM_CH-1:0] lock;
  logic [NUM_CH-1:0] state;
  logic [NUM_CH-1:0] changed;
  logic [NUM_CH-1:0] sw_stable;

  modport master (
    output sw, uart_toggle, uart_wr, uart_wdata, lock,
    input  state, changed, sw_stable
  );

  modport slave (
    input  sw, uart_toggle, uart_wr, uart_wdata, lock,
    output state, changed, sw_stable
  );
endinterface

// File: rtl/switch_mode_bank.sv
// Bank of mode bits set by debounced slide switches and UART toggle/write commands.
// Build option: define SW_DEBOUNCE_EN to insert per-channel debounce counters.
`timescale 1ns/1ps
module switch_mode_bank #(
  parameter int NUM_CH          = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input logic               i_clk,
  input logic               i_rst,
  switch_mode_bank_if.slave bus
);

  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;
  logic [NUM_CH-1:0] r_stable;
  logic [NUM_CH-1:0] r_state;
  logic [NUM_CH-1:0] r_changed;
  logic [NUM_CH-1:0] w_sw_edge;
  logic [NUM_CH-1:0] w_stable_next;
  logic [NUM_CH-1:0] w_state_next;

  if (DEBOUNCE_CYCLES < 2 || CNT_W < $clog2(DEBOUNCE_CYCLES)) begin : g_bad_cfg
    $error("switch_mode_bank: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
  end

  // Synchroniser runs freely; reset only affects the stages that follow it.
  always_ff @(posedge i_clk) begin
    r_sync1 <= bus.sw;
    r_sync2 <= r_sync1;
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
`ifdef SW_DEBOUNCE_EN
      logic [CNT_W-1:0] r_cnt;
      logic             w_differs;
      logic             w_expired;

      assign w_differs          = r_sync2[gi] != r_stable[gi];
      assign w_expired          = w_differs && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
      assign w_sw_edge[gi]      = w_expired;
      assign w_stable_next[gi]  = w_expired ? r_sync2[gi] : r_stable[gi];

      // Any return to the stable level restarts the qualification window.
      always_ff @(posedge i_clk) begin
        if (!i_rst || !w_differs || w_expired) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
`else
      assign w_sw_edge[gi]     = r_sync2[gi] ^ r_stable[gi];
      assign w_stable_next[gi] = r_sync2[gi];
`endif
    end
  endgenerate

  // Switch edge beats UART write, which beats UART toggle; lock gates UART only.
  always_comb begin
    w_state_next = r_state;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_sw_edge[i]) begin
        w_state_next[i] = r_sync2[i];
      end else if (bus.uart_wr && !bus.lock[i]) begin
        w_state_next[i] = bus.uart_wdata[i];
      end else if (bus.uart_toggle[i] && !bus.lock[i]) begin
        w_state_next[i] = ~r_state[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_stable  <= r_sync2;
      r_state   <= r_sync2;
      r_changed <= '0;
    end else begin
      r_stable  <= w_stable_next;
      r_state   <= w_state_next;
      r_changed <= w_state_next ^ r_state;
    end
  end

  assign bus.state     = r_state;
  assign bus.changed   = r_changed;
  assign bus.sw_stable = r_stable;

endmodule

// File: tb/tb_switch_mode_bank.sv
// Scoreboard bench for switch_mode_bank (NUM_CH=2, DEBOUNCE_CYCLES=4); expected
// switch latency follows the SW_DEBOUNCE_EN build option.
`timescale 1ns/1ps
module tb_switch_mode_bank;
  localparam int NUM_CH = 2;
  localparam int DEB    = 4;
`ifdef SW_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
`else
  localparam int LAT = 3;
`endif

  typedef struct packed {
    logic       rst;
    logic [1:0] sw;
    logic [1:0] tog;
    logic       wr;
    logic [1:0] wd;
    logic [1:0] lk;
    logic [5:0] exp;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [5:0] sb[$];

  switch_mode_bank_if #(.NUM_CH(NUM_CH)) bus ();

  switch_mode_bank #(
    .NUM_CH(NUM_CH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic row_t mk(input logic r, input logic [1:0] sw, input logic [1:0] tog,
                              input logic wr, input logic [1:0] wd, input logic [1:0] lk,
                              input logic [1:0] st, input logic [1:0] ch, input logic [1:0] stb);
    return {r, sw, tog, wr, wd, lk, st, ch, stb};
  endfunction

  function automatic logic [5:0] obs();
    return {bus.state, bus.changed, bus.sw_stable};
  endfunction

  task automatic apply(input row_t r);
    rst             = r.rst;
    bus.sw          = r.sw;
    bus.uart_toggle = r.tog;
    bus.uart_wr     = r.wr;
    bus.uart_wdata  = r.wd;
    bus.lock        = r.lk;
    sb.push_back(r.exp);
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [5:0] e, got;
    apply(mk(1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    void'(sb.pop_front());
    repeat (3) tick();
    rows.push_back(mk(1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10));
    rows.push_back(mk(1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10));
    rows.push_back(mk(1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10));
    foreach (rows[i]) begin
      apply(rows[i]); tick();
      e = sb.pop_front(); got = obs(); n_total++;
      if (got !== e) $display("FAIL reset[%0d]: state,changed,sw_stable=%b,%b,%b required %b,%b,%b", i, got[5:4], got[3:2], got[1:0], e[5:4], e[3:2], e[1:0]);
      else begin n_pass++; $display("reset[%0d] ok state=%b changed=%b sw_stable=%b", i, got[5:4], got[3:2], got[1:0]); end
    end
  endtask

  task automatic test_toggle();
    row_t rows[$];
    logic [5:0] e, got;
    rows.push_back(mk(1'b1, 2'b10, 2'b01, 1'b0, 2'b00, 2'b00, 2'b11, 2'b01, 2'b10));
    rows.push_back(mk(1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10));
    foreach (rows[i]) begin
      apply(rows[i]); tick();
      e = sb.pop_front(); got = obs(); n_total++;
      if (got !== e) $display("FAIL toggle[%0d]: state,changed,sw_stable=%b,%b,%b required %b,%b,%b", i, got[5:4], got[3:2], got[1:0], e[5:4], e[3:2], e[1:0]);
      else begin n_pass++; $display("toggle[%0d] ok state=%b changed=%b sw_stable=%b", i, got[5:4], got[3:2], got[1:0]); end
    end
  endtask

  task automatic test_lock();
    row_t rows[$];
    logic [5:0] e, got;
    rows.push_back(mk(1'b1, 2'b10, 2'b00, 1'b1, 2'b00, 2'b11, 2'b11, 2'b00, 2'b10));
    rows.push_back(mk(1'b1, 2'b10, 2'b11, 1'b0, 2'b00, 2'b11, 2'b11, 2'b00, 2'b10));
    rows.push_back(mk(1'b1, 2'b10, 2'b11, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10));
    rows.push_back(mk(1'b1, 2'b10, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10));
    rows.push_back(mk(1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10));
    foreach (rows[i]) begin
      apply(rows[i]); tick();
      e = sb.pop_front(); got = obs(); n_total++;
      if (got !== e) $display("FAIL lock[%0d]: state,changed,sw_stable=%b,%b,%b required %b,%b,%b", i, got[5:4], got[3:2], got[1:0], e[5:4], e[3:2], e[1:0]);
      else begin n_pass++; $display("lock[%0d] ok state=%b changed=%b sw_stable=%b", i, got[5:4], got[3:2], got[1:0]); end
    end
  endtask

  task automatic test_bounce();
    row_t rows[$];
    row_t r;
    logic [5:0] e, got;
    for (int i = 0; i < 8; i++) begin
      r = mk(1'b1, (i == 1) ? 2'b11 : 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
`ifndef SW_DEBOUNCE_EN
      if (i == 3) r.exp = {2'b01, 2'b01, 2'b11};
      if (i == 4) r.exp = {2'b00, 2'b01, 2'b10};
`endif
      rows.push_back(r);
    end
    foreach (rows[i]) begin
      apply(rows[i]); tick();
      e = sb.pop_front(); got = obs(); n_total++;
      if (got !== e) $display("FAIL bounce[%0d]: state,changed,sw_stable=%b,%b,%b required %b,%b,%b", i, got[5:4], got[3:2], got[1:0], e[5:4], e[3:2], e[1:0]);
      else begin n_pass++; $display("bounce[%0d] ok state=%b changed=%b sw_stable=%b", i, got[5:4], got[3:2], got[1:0]); end
    end
  endtask

  task automatic test_hold();
    row_t rows[$];
    logic [5:0] e, got;
    for (int k = 1; k <= LAT + 1; k++) begin
      if (k < LAT)       rows.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10));
      else if (k == LAT) rows.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11));
      else               rows.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b11));
    end
    foreach (rows[i]) begin
      apply(rows[i]); tick();
      e = sb.pop_front(); got = obs(); n_total++;
      if (got !== e) $display("FAIL hold[%0d]: state,changed,sw_stable=%b,%b,%b required %b,%b,%b", i, got[5:4], got[3:2], got[1:0], e[5:4], e[3:2], e[1:0]);
      else begin n_pass++; $display("hold[%0d] ok state=%b changed=%b sw_stable=%b", i, got[5:4], got[3:2], got[1:0]); end
    end
  endtask

  task automatic test_collision();
    row_t rows[$];
    logic [5:0] e, got;
    // Bring the stable level of channel 1 down without touching state.
    for (int k = 1; k <= LAT + 1; k++)
      rows.push_back(mk(1'b1, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, (k < LAT) ? 2'b11 : 2'b01));
    for (int k = 1; k < LAT; k++)
      rows.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01));
    rows.push_back(mk(1'b1, 2'b11, 2'b10, 1'b1, 2'b01, 2'b00, 2'b11, 2'b10, 2'b11));
    rows.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11));
    rows.push_back(mk(1'b1, 2'b11, 2'b11, 1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11));
    rows.push_back(mk(1'b1, 2'b11, 2'b11, 1'b1, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11));
    rows.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b11));
    foreach (rows[i]) begin
      apply(rows[i]); tick();
      e = sb.pop_front(); got = obs(); n_total++;
      if (got !== e) $display("FAIL collision[%0d]: state,changed,sw_stable=%b,%b,%b required %b,%b,%b", i, got[5:4], got[3:2], got[1:0], e[5:4], e[3:2], e[1:0]);
      else begin n_pass++; $display("collision[%0d] ok state=%b changed=%b sw_stable=%b", i, got[5:4], got[3:2], got[1:0]); end
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    logic [5:0] e, got;
    for (int k = 1; k <= 4; k++)
      rows.push_back(mk(1'b1, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, (k >= LAT) ? 2'b01 : 2'b11));
    for (int k = 1; k <= 4; k++)
      rows.push_back(mk(1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01));
    for (int k = 1; k <= 2; k++)
      rows.push_back(mk(1'b1, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01));
    // A fresh switch change after release needs the full latency again.
    for (int k = 1; k <= LAT + 1; k++) begin
      if (k < LAT)       rows.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01));
      else if (k == LAT) rows.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 2'b11, 2'b10, 2'b11));
      else               rows.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11));
    end
    foreach (rows[i]) begin
      apply(rows[i]); tick();
      e = sb.pop_front(); got = obs(); n_total++;
      if (got !== e) $display("FAIL reset_mid[%0d]: state,changed,sw_stable=%b,%b,%b required %b,%b,%b", i, got[5:4], got[3:2], got[1:0], e[5:4], e[3:2], e[1:0]);
      else begin n_pass++; $display("reset_mid[%0d] ok state=%b changed=%b sw_stable=%b", i, got[5:4], got[3:2], got[1:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_lock();
    test_bounce();
    test_hold();
    test_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
